// File: rtl/pwm_ramp_sequencer_if.sv
// Control/status bundle between the duty-cycle sequencer and its user side.
// Master drives target/strobes; slave (the sequencer) returns Npwm and status flags.
interface pwm_ramp_sequencer_if;
    logic       ena;
    logic       tick;
    logic       load;
    logic [6:0] target;
    logic       stop;
    logic [6:0] Npwm;
    logic       busy;
    logic       done;
    logic       stopped;

    modport master (
        output ena, tick, load, target, stop,
        input  Npwm, busy, done, stopped
    );

    modport slave (
        input  ena, tick, load, target, stop,
        output Npwm, busy, done, stopped
    );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Slews Npwm toward a clamped target by STEP every DIV ticks; first step DIV ticks after load, no backpressure (ena=0 freezes).
// PWM_SOFT_STOP_EN: stop ramps down through STOP; otherwise stop zeroes Npwm and halts at once.
module pwm_ramp_sequencer #(
    parameter int MAX_DUTY   = 100,
    parameter int STEP       = 1,
    parameter int DIV        = 4,
    parameter int RESET_DUTY = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_ramp_sequencer_if.slave  bus
);

    localparam int              CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [6:0]      C_MAX   = 7'(MAX_DUTY);
    localparam logic [6:0]      C_STEP  = 7'(STEP);
    localparam logic [6:0]      C_RST   = 7'(RESET_DUTY);
    localparam logic [CW-1:0]   C_LAST  = CW'(DIV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_STOP, ST_HALT} state_t;

    state_t          r_state, w_state_n;
    logic [6:0]      r_npwm, w_npwm_n;
    logic [6:0]      r_tgt, w_tgt_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic            r_done, w_done_n;
    logic            r_stopped;
    logic [6:0]      w_clamp;
    logic [6:0]      w_stepped;

    always_comb begin
        w_clamp = (bus.target > C_MAX) ? C_MAX : bus.target;
    end

    // One step toward r_tgt, clipped so it lands exactly on the target.
    always_comb begin
        w_stepped = r_npwm;
        if (r_tgt > r_npwm) begin
            w_stepped = ((r_tgt - r_npwm) > C_STEP) ? (r_npwm + C_STEP) : r_tgt;
        end else if (r_tgt < r_npwm) begin
            w_stepped = ((r_npwm - r_tgt) > C_STEP) ? (r_npwm - C_STEP) : r_tgt;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_npwm_n  = r_npwm;
        w_tgt_n   = r_tgt;
        w_cnt_n   = r_cnt;
        w_done_n  = r_done;
        if (bus.ena) begin
            w_done_n = 1'b0;
            case (r_state)
                ST_IDLE, ST_RAMP: begin
                    if (bus.stop) begin
`ifdef PWM_SOFT_STOP_EN
                        w_tgt_n   = 7'd0;
                        w_cnt_n   = '0;
                        w_state_n = ST_STOP;
`else
                        w_tgt_n   = 7'd0;
                        w_npwm_n  = 7'd0;
                        w_cnt_n   = '0;
                        w_state_n = ST_HALT;
`endif
                    end else if (bus.load) begin
                        w_tgt_n = w_clamp;
                        if (w_clamp == r_npwm) begin
                            if (r_state == ST_RAMP) begin
                                w_state_n = ST_IDLE;
                                w_done_n  = 1'b1;
                            end
                        end else begin
                            w_state_n = ST_RAMP;
                            // Retarget keeps the pacing phase; a fresh ramp starts a full period.
                            if (r_state == ST_IDLE) begin
                                w_cnt_n = '0;
                            end
                        end
                    end else if (bus.tick && (r_state == ST_RAMP)) begin
                        if (r_cnt == C_LAST) begin
                            w_cnt_n  = '0;
                            w_npwm_n = w_stepped;
                            if (w_stepped == r_tgt) begin
                                w_state_n = ST_IDLE;
                                w_done_n  = 1'b1;
                            end
                        end else begin
                            w_cnt_n = r_cnt + 1'b1;
                        end
                    end
                end
`ifdef PWM_SOFT_STOP_EN
                ST_STOP: begin
                    if (r_npwm == 7'd0) begin
                        w_cnt_n   = '0;
                        w_state_n = ST_HALT;
                    end else if (bus.tick) begin
                        if (r_cnt == C_LAST) begin
                            w_cnt_n  = '0;
                            w_npwm_n = w_stepped;
                            if (w_stepped == 7'd0) begin
                                w_state_n = ST_HALT;
                            end
                        end else begin
                            w_cnt_n = r_cnt + 1'b1;
                        end
                    end
                end
`endif
                ST_HALT: begin
                    w_npwm_n = 7'd0;
                    if (!bus.stop) begin
                        w_tgt_n   = 7'd0;
                        w_state_n = ST_IDLE;
                    end
                end
                default: begin
                    w_state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_npwm    <= C_RST;
            r_tgt     <= C_RST;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_stopped <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_npwm    <= w_npwm_n;
            r_tgt     <= w_tgt_n;
            r_cnt     <= w_cnt_n;
            r_done    <= w_done_n;
            r_stopped <= (w_state_n == ST_HALT);
        end
    end

    assign bus.Npwm    = r_npwm;
    assign bus.busy    = (r_state == ST_RAMP) || (r_state == ST_STOP);
    assign bus.done    = r_done;
    assign bus.stopped = r_stopped;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: STEP=1 and STEP=3 instances, DIV=4, tick every cycle.
// Expected Npwm steps are queued when a load is driven and popped as the DUT moves.
module tb_pwm_ramp_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic ena_r;
    logic tick_r;

    pwm_ramp_sequencer_if b1 ();
    pwm_ramp_sequencer_if b3 ();

    assign b1.ena  = ena_r;
    assign b1.tick = tick_r;
    assign b3.ena  = ena_r;
    assign b3.tick = tick_r;

    pwm_ramp_sequencer #(.MAX_DUTY(100), .STEP(1), .DIV(4), .RESET_DUTY(0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    pwm_ramp_sequencer #(.MAX_DUTY(100), .STEP(3), .DIV(4), .RESET_DUTY(0)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    logic [6:0] o_npwm    [2];
    logic       o_busy    [2];
    logic       o_done    [2];
    logic       o_stopped [2];

    always_comb begin
        o_npwm[0]    = b1.Npwm;
        o_busy[0]    = b1.busy;
        o_done[0]    = b1.done;
        o_stopped[0] = b1.stopped;
        o_npwm[1]    = b3.Npwm;
        o_busy[1]    = b3.busy;
        o_done[1]    = b3.done;
        o_stopped[1] = b3.stopped;
    end

    int         checks = 0;
    int         errors = 0;
    int         dn_cnt;
    int         lat;
    logic [6:0] sbq [$];

    typedef struct {
        int         w;
        logic [6:0] tgt;
        logic [6:0] fin;
        logic       bsy;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void push_ramp(input int w, input logic [6:0] from, input logic [6:0] to);
        logic [6:0] v;
        logic [6:0] st;
        v  = from;
        st = (w == 0) ? 7'd1 : 7'd3;
        while (v != to) begin
            if (to > v) v = ((to - v) > st) ? (v + st) : to;
            else        v = ((v - to) > st) ? (v - st) : to;
            sbq.push_back(v);
        end
    endfunction

    task automatic drive(input int w, input logic ld, input logic [6:0] t, input logic sp);
        if (w == 0) begin
            b1.load = ld; b1.target = t; b1.stop = sp;
        end else begin
            b3.load = ld; b3.target = t; b3.stop = sp;
        end
    endtask

    // Called right after a negedge; ends on the sample just after the load edge.
    task automatic do_load(input int w, input logic [6:0] t);
        drive(w, 1'b1, t, 1'b0);
        @(negedge clk);
        drive(w, 1'b0, t, 1'b0);
        dn_cnt += int'(o_done[w]);
    endtask

    task automatic watch(input int w, input logic [6:0] until_v, input bit wait_idle, input string name);
        logic [6:0] prev;
        bit         ok;
        prev = o_npwm[w];
        lat  = -1;
        ok   = 1'b0;
        for (int c = 1; c <= 1000 && !ok; c++) begin
            @(negedge clk);
            if (o_npwm[w] != prev) begin
                if (lat < 0) lat = c;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s unexpected step actual=%0d from=%0d", name, o_npwm[w], prev);
                end else begin
                    chk(name, 32'(o_npwm[w]), 32'(sbq.pop_front()));
                end
                prev = o_npwm[w];
            end
            dn_cnt += int'(o_done[w]);
            if (o_npwm[w] == until_v && sbq.size() == 0 && (!wait_idle || !o_busy[w])) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d required=%0d", name, o_npwm[w], until_v);
            sbq.delete();
        end
    endtask

    task automatic quiet(input int w, input int n, input string name);
        logic [6:0] prev;
        prev = o_npwm[w];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dn_cnt += int'(o_done[w]);
        end
        chk(name, 32'(o_npwm[w]), 32'(prev));
    endtask

    initial begin
        vecs[0] = '{0, 7'd10,  7'd10,  1'b1};
        vecs[1] = '{0, 7'd120, 7'd100, 1'b1};
        vecs[2] = '{0, 7'd100, 7'd100, 1'b0};
        vecs[3] = '{0, 7'd60,  7'd60,  1'b1};
        vecs[4] = '{0, 7'd0,   7'd0,   1'b1};
        vecs[5] = '{1, 7'd10,  7'd10,  1'b1};
        vecs[6] = '{1, 7'd0,   7'd0,   1'b1};
        vecs[7] = '{1, 7'd127, 7'd100, 1'b1};

        rst    = 1'b1;
        ena_r  = 1'b1;
        tick_r = 1'b1;
        drive(0, 1'b0, 7'd0, 1'b0);
        drive(1, 1'b0, 7'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int w = 0; w < 2; w++) begin
            chk("rst_npwm",    32'(o_npwm[w]),    32'd0);
            chk("rst_busy",    32'(o_busy[w]),    32'd0);
            chk("rst_done",    32'(o_done[w]),    32'd0);
            chk("rst_stopped", 32'(o_stopped[w]), 32'd0);
        end

        // Table: ramps, clamp, no-op reload, STEP=3 non-overshoot.
        for (int i = 0; i < 8; i++) begin
            int w;
            w      = vecs[i].w;
            dn_cnt = 0;
            push_ramp(w, o_npwm[w], vecs[i].fin);
            do_load(w, vecs[i].tgt);
            chk("busy_after_load", 32'(o_busy[w]), 32'(vecs[i].bsy));
            watch(w, vecs[i].fin, 1'b1, "ramp_step");
            if (vecs[i].bsy) chk("first_step_latency", lat, 32'd4);
            quiet(w, 6, "ramp_hold");
            chk("done_pulses", dn_cnt, vecs[i].bsy ? 32'd1 : 32'd0);
            chk("final_npwm", 32'(o_npwm[w]), 32'(vecs[i].fin));
            chk("idle_busy", 32'(o_busy[w]), 32'd0);
        end

        // Retarget downward mid-ramp.
        dn_cnt = 0;
        push_ramp(0, 7'd0, 7'd55);
        do_load(0, 7'd60);
        watch(0, 7'd55, 1'b0, "t4_up");
        push_ramp(0, 7'd55, 7'd40);
        do_load(0, 7'd40);
        watch(0, 7'd40, 1'b1, "t4_down");
        quiet(0, 6, "t4_hold");
        chk("t4_done_once", dn_cnt, 32'd1);

        // Retarget to the current value mid-ramp: immediate done.
        push_ramp(0, 7'd40, 7'd45);
        do_load(0, 7'd50);
        watch(0, 7'd45, 1'b0, "eq_up");
        dn_cnt = 0;
        do_load(0, 7'd45);
        chk("eq_busy", 32'(o_busy[0]), 32'd0);
        chk("eq_done", 32'(o_done[0]), 32'd1);
        quiet(0, 6, "eq_hold");
        chk("eq_done_once", dn_cnt, 32'd1);

        // Stop with a simultaneous load from Npwm=30.
        push_ramp(0, 7'd45, 7'd30);
        do_load(0, 7'd30);
        watch(0, 7'd30, 1'b1, "t5_prep");
        dn_cnt = 0;
        drive(0, 1'b1, 7'd80, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 7'd80, 1'b1);
`ifdef PWM_SOFT_STOP_EN
        chk("t5_soft_busy", 32'(o_busy[0]), 32'd1);
        push_ramp(0, 7'd30, 7'd0);
        watch(0, 7'd0, 1'b1, "t5_soft_step");
`else
        chk("t5_hard_npwm", 32'(o_npwm[0]), 32'd0);
        chk("t5_hard_busy", 32'(o_busy[0]), 32'd0);
`endif
        chk("t5_stopped", 32'(o_stopped[0]), 32'd1);
        drive(0, 1'b1, 7'd50, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 7'd50, 1'b1);
        quiet(0, 4, "t5_halt_hold");
        chk("t5_halt_npwm", 32'(o_npwm[0]), 32'd0);
        chk("t5_halt_stopped", 32'(o_stopped[0]), 32'd1);
        chk("t5_halt_busy", 32'(o_busy[0]), 32'd0);
        chk("t5_no_done", dn_cnt, 32'd0);
        drive(0, 1'b0, 7'd50, 1'b0);
        @(negedge clk);
        chk("t5_release_stopped", 32'(o_stopped[0]), 32'd0);
        chk("t5_release_busy", 32'(o_busy[0]), 32'd0);
        dn_cnt = 0;
        push_ramp(0, 7'd0, 7'd5);
        do_load(0, 7'd5);
        watch(0, 7'd5, 1'b1, "t5_resume");
        chk("t5_resume_done", dn_cnt, 32'd1);

        // Freeze with ena=0 mid-ramp (21 cycles, not a multiple of DIV), then reset mid-ramp.
        push_ramp(0, 7'd5, 7'd20);
        do_load(0, 7'd50);
        watch(0, 7'd20, 1'b0, "t6_up");
        ena_r = 1'b0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            chk("t6_frozen_npwm", 32'(o_npwm[0]), 32'd20);
        end
        chk("t6_frozen_busy", 32'(o_busy[0]), 32'd1);
        ena_r = 1'b1;
        push_ramp(0, 7'd20, 7'd22);
        watch(0, 7'd22, 1'b0, "t6_resume");
        chk("t6_cnt_frozen", lat, 32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_npwm", 32'(o_npwm[0]), 32'd0);
        chk("t6_rst_busy", 32'(o_busy[0]), 32'd0);
        chk("t6_rst_done", 32'(o_done[0]), 32'd0);
        dn_cnt = 0;
        quiet(0, 8, "t6_rst_hold");
        chk("t6_rst_no_done", dn_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
